vector_sweep_capture: RTL and testbench

Exhaustive stimulus sequencer and response capture stage that sits directly upstream of the 5-input combinational function block (task_4).
- Drives every input combination onto the block's inputs in ascending binary order.
- Waits a programmable settle time after each vector, then samples the block's output.
- Assembles the full truth table into a response register, with a count of ones.
- Replaces hand-written delay-and-display stimulus with a synthesizable, self-timed sweep that lab benches and on-board checks can use.

---
 rtl/vector_sweep_capture_pkg.sv | 13 +
 rtl/vector_sweep_capture.sv | 102 ++++++++++
 tb/tb_vector_sweep_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vector_sweep_capture_pkg.sv
// Shared definitions for lab sweep stages: FSM state encoding and default sweep sizing.
package vector_sweep_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_t;

   localparam int unsigned N_IN_DEFAULT   = 5;
   localparam int unsigned SETTLE_DEFAULT = 1;

endpackage : vector_sweep_capture_pkg

// File: rtl/vector_sweep_capture.sv
// Exhaustive ascending-order input sweep of a combinational block, capturing its
// truth table into resp with a running count of ones.
module vector_sweep_capture
   import vector_sweep_capture_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEFAULT,
   parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 z_in,
   output logic [N_IN-1:0]      x_out,
   output logic                 busy,
   output logic                 done,
   output logic [(1<<N_IN)-1:0] resp,
   output logic [N_IN:0]        ones
);

   localparam int unsigned N_VEC = 1 << N_IN;
   localparam int unsigned CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   sweep_state_t        r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [N_IN-1:0]     r_vec;
   logic                r_busy;
   logic                r_done;
   logic [N_VEC-1:0]    r_resp;
   logic [N_IN:0]       r_ones;

   logic                w_last_vec;

   assign w_last_vec = (r_vec == N_IN'(N_VEC - 1));

   // r_vec doubles as x_out: it is zeroed whenever the FSM leaves RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_vec   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_resp  <= '0;
         r_ones  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_resp  <= '0;
                  r_ones  <= '0;
                  r_vec   <= '0;
                  r_cnt   <= CNT_W'(SETTLE);
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_vec   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_resp[r_vec] <= z_in;
                  r_ones        <= r_ones + (N_IN+1)'(z_in);
                  if (w_last_vec) begin
                     r_vec   <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_vec <= r_vec + N_IN'(1);
                     r_cnt <= CNT_W'(SETTLE);
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_vec   <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign x_out = r_vec;
   assign busy  = r_busy;
   assign done  = r_done;
   assign resp  = r_resp;
   assign ones  = r_ones;

endmodule : vector_sweep_capture

// File: tb/tb_vector_sweep_capture.sv
// Scoreboard bench: three sweepers (SETTLE 0/1/2) driven one at a time; a monitor
// checks x_out ordering every busy cycle and resp/ones/run length at each done pulse.
module tb_vector_sweep_capture;

   typedef struct {
      int          inst;
      logic [31:0] resp;
      logic [5:0]  ones;
      int          busy_cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start0, start1, start2;
   logic abort0, abort1, abort2;
   logic z0, z1, z2;
   logic [4:0]  x0, x1, x2;
   logic        busy0, busy1, busy2;
   logic        done0, done1, done2;
   logic [31:0] resp0, resp1, resp2;
   logic [5:0]  ones0, ones1, ones2;

   logic       m0;
   logic [1:0] m1;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   bc[3];

   always #5 clk = ~clk;

   // Reference function standing in for the downstream block under sweep.
   function automatic logic ref_fn(input logic [4:0] x);
      return (x[0] & x[2] & x[4]) | (x[1] & x[3]);
   endfunction

   assign z0 = m0 ? 1'b1 : (&x0);
   assign z1 = (m1 == 2'd0) ? 1'b0 : (m1 == 2'd1) ? ref_fn(x1) : 1'b1;
   assign z2 = x2[0];

   vector_sweep_capture #(.N_IN(5), .SETTLE(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .z_in(z0),
      .x_out(x0), .busy(busy0), .done(done0), .resp(resp0), .ones(ones0));
   vector_sweep_capture #(.N_IN(5), .SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .z_in(z1),
      .x_out(x1), .busy(busy1), .done(done1), .resp(resp1), .ones(ones1));
   vector_sweep_capture #(.N_IN(5), .SETTLE(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .z_in(z2),
      .x_out(x2), .busy(busy2), .done(done2), .resp(resp2), .ones(ones2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic mon(input int i, input int s, input logic b, input logic d,
                      input logic [4:0] x, input logic [31:0] r, input logic [5:0] o);
      exp_t e;
      if (b) begin
         bc[i]++;
         check($sformatf("x_out order s%0d", i), 64'(x), 64'((bc[i] - 1) / (s + 1)));
      end
      if (d) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done s%0d: got done with empty scoreboard", i);
         end else begin
            e = q.pop_front();
            check($sformatf("done inst s%0d", i), 64'(i), 64'(e.inst));
            check($sformatf("resp s%0d", i), 64'(r), 64'(e.resp));
            check($sformatf("ones s%0d", i), 64'(o), 64'(e.ones));
            check($sformatf("busy len s%0d", i), 64'(bc[i]), 64'(e.busy_cycles));
            check($sformatf("x_out at done s%0d", i), 64'(x), 64'(0));
         end
      end
      if (!b) bc[i] = 0;
   endtask

   // Monitor: decoupled from stimulus, samples on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, 0, busy0, done0, x0, resp0, ones0);
         mon(1, 1, busy1, done1, x1, resp1, ones1);
         mon(2, 2, busy2, done2, x2, resp2, ones2);
      end else begin
         bc[0] = 0; bc[1] = 0; bc[2] = 0;
      end
   end

   task automatic push(input int inst, input logic [31:0] r, input logic [5:0] o, input int len);
      exp_t e;
      e.inst = inst; e.resp = r; e.ones = o; e.busy_cycles = len;
      q.push_back(e);
   endtask

   task automatic pulse_start(input int inst);
      @(negedge clk);
      case (inst)
         0: start0 = 1'b1;
         1: start1 = 1'b1;
         default: start2 = 1'b1;
      endcase
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_done(input int inst, input int limit);
      int n = 0;
      logic d;
      d = 1'b0;
      while (!d && n < limit) begin
         @(negedge clk);
         n++;
         d = (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
      end
      if (!d) begin
         checks++;
         errors++;
         $display("FAIL timeout s%0d: no done within %0d cycles", inst, limit);
      end
      @(negedge clk);
      d = (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
      check($sformatf("done one cycle s%0d", inst), 64'(d), 64'(0));
   endtask

   initial begin
      logic [31:0] t4;
      logic [5:0]  t4_ones;
      int n;

      rst_n = 1'b0;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
      m0 = 1'b0; m1 = 2'd0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'({busy0, busy1, busy2}), 64'(0));
      check("reset done", 64'({done0, done1, done2}), 64'(0));
      check("reset x_out", 64'({x0, x1, x2}), 64'(0));
      check("reset resp1", 64'(resp1), 64'(0));
      check("reset ones", 64'({ones0, ones1, ones2}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // z tied low, SETTLE=1: 64 busy cycles, empty table
      m1 = 2'd0;
      push(1, 32'h0000_0000, 6'd0, 64);
      pulse_start(1);
      wait_done(1, 100);

      // 5-input AND, SETTLE=0
      push(0, 32'h8000_0000, 6'd1, 32);
      pulse_start(0);
      wait_done(0, 60);

      // z = x[0], SETTLE=2, with ignored mid-run start pulses
      push(2, 32'hAAAA_AAAA, 6'd16, 96);
      pulse_start(2);
      repeat (20) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      repeat (30) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      wait_done(2, 100);

      // Reference function, SETTLE=1
      t4 = '0;
      t4_ones = '0;
      for (int i = 0; i < 32; i++) begin
         t4[i] = ref_fn(5'(i));
         t4_ones = t4_ones + 6'(t4[i]);
      end
      m1 = 2'd1;
      push(1, t4, t4_ones, 64);
      pulse_start(1);
      wait_done(1, 100);
      check("resp1[0] all zero", 64'(resp1[0]), 64'(0));
      check("resp1[21] x1x3x5", 64'(resp1[21]), 64'(1));
      check("resp1[10] x2x4", 64'(resp1[10]), 64'(1));
      check("resp1[31] all one", 64'(resp1[31]), 64'(1));

      // z = 1, SETTLE=0, abort on the sample cycle of vector 10
      m0 = 1'b1;
      pulse_start(0);
      n = 0;
      while (x0 != 5'd10 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("abort reached v10", 64'(x0), 64'(10));
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort busy", 64'(busy0), 64'(0));
      check("abort done", 64'(done0), 64'(0));
      check("abort x_out", 64'(x0), 64'(0));
      check("abort resp", 64'(resp0), 64'h0000_03FF);
      check("abort ones", 64'(ones0), 64'(10));
      repeat (3) @(negedge clk);
      check("abort no late done", 64'(done0), 64'(0));
      check("abort resp held", 64'(resp0), 64'h0000_03FF);

      // Reset mid-sweep at vector 7, then a full all-ones sweep
      m1 = 2'd2;
      pulse_start(1);
      n = 0;
      while (x1 != 5'd7 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("reset reached v7", 64'(x1), 64'(7));
      rst_n = 1'b0;
      #1;
      check("midreset busy", 64'(busy1), 64'(0));
      check("midreset done", 64'(done1), 64'(0));
      check("midreset x_out", 64'(x1), 64'(0));
      check("midreset resp", 64'(resp1), 64'(0));
      check("midreset ones", 64'(ones1), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      push(1, 32'hFFFF_FFFF, 6'd32, 64);
      pulse_start(1);
      wait_done(1, 100);

      repeat (2) @(negedge clk);
      check("scoreboard drained", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vector_sweep_capture
